// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data SRAM between the core load/store
// port and an external host port. The core normally has priority. A host that
// has been denied MAX_WAIT consecutive cycles is forced through for one cycle
// so it cannot be starved. Read data returns one cycle after the grant and is
// steered to whichever side issued the read.
module dmem_arbiter #(
    parameter int AW       = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          core_read_i,
    input  logic          core_write_i,
    input  logic [3:0]    core_strb_i,
    input  logic [31:0]   core_addr_i,
    input  logic [31:0]   core_wdata_i,
    output logic [31:0]   core_rdata_o,
    output logic          core_stall_o,

    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [3:0]    host_strb_i,
    input  logic [31:0]   host_addr_i,
    input  logic [31:0]   host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [31:0]   host_rdata_o,

    output logic          sram_en_o,
    output logic [3:0]    sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);

    // Read-return owner, i.e. who issued the read whose data is on sram_rdata_i.
    //   state   | meaning
    //   RD_NONE | no read last cycle; sram_rdata_i is not claimed
    //   RD_CORE | core read last cycle; data goes to core and the hold register
    //   RD_HOST | host read last cycle; data goes out with host_rvalid_o
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_HOST = 2'd2
    } rd_owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    rd_owner_t   rd_owner;
    rd_owner_t   rd_owner_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nxt;
    logic [31:0] rdata_hold;
    logic [31:0] rdata_hold_nxt;

    logic core_req;
    logic force_host;
    logic gnt_core;
    logic gnt_host;
    logic unused_bits;

    assign core_req   = core_read_i | core_write_i;
    assign force_host = (wait_cnt == MAX_WAIT_C);

    // Only the word-index bits of each address reach the SRAM.
    assign unused_bits = ^{core_addr_i[31:AW+2], core_addr_i[1:0],
                           host_addr_i[31:AW+2], host_addr_i[1:0]};

    // Grant selection. Reset masks every grant so nothing reaches the SRAM.
    always_comb begin
        gnt_core = 1'b0;
        gnt_host = 1'b0;
        if (!rst_i) begin
            if (host_req_i && (force_host || !core_req)) begin
                gnt_host = 1'b1;
            end else if (core_req) begin
                gnt_core = 1'b1;
            end
        end
    end

    assign host_gnt_o   = gnt_host;
    assign core_stall_o = core_req & gnt_host;

    // Steer the granted requester onto the SRAM port; the port is quiet when idle.
    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 4'b0000;
        sram_addr_o  = '0;
        sram_wdata_o = 32'h0;
        if (gnt_host) begin
            sram_en_o    = 1'b1;
            sram_we_o    = host_we_i ? host_strb_i : 4'b0000;
            sram_addr_o  = host_addr_i[AW+1:2];
            sram_wdata_o = host_wdata_i;
        end else if (gnt_core) begin
            sram_en_o    = 1'b1;
            // A simultaneous read and write from the core is treated as a write.
            sram_we_o    = core_write_i ? core_strb_i : 4'b0000;
            sram_addr_o  = core_addr_i[AW+1:2];
            sram_wdata_o = core_wdata_i;
        end
    end

    // Next-state: starvation counter, read-return owner and core data hold.
    always_comb begin
        wait_cnt_nxt = 4'd0;
        if (host_req_i && !gnt_host) begin
            wait_cnt_nxt = (wait_cnt >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt + 4'd1;
        end

        rd_owner_nxt = RD_NONE;
        if (gnt_host && !host_we_i) begin
            rd_owner_nxt = RD_HOST;
        end else if (gnt_core && !core_write_i) begin
            rd_owner_nxt = RD_CORE;
        end

        rdata_hold_nxt = rdata_hold;
        if (rd_owner == RD_CORE) begin
            rdata_hold_nxt = sram_rdata_i;
        end
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt   <= 4'd0;
            rd_owner   <= RD_NONE;
            rdata_hold <= 32'h0;
        end else begin
            wait_cnt   <= wait_cnt_nxt;
            rd_owner   <= rd_owner_nxt;
            rdata_hold <= rdata_hold_nxt;
        end
    end

    // Read-return steering. The core sees live data on the return cycle and
    // the held copy afterwards, so its load result stays stable.
    always_comb begin
        core_rdata_o  = (rd_owner == RD_CORE) ? sram_rdata_i : rdata_hold;
        host_rvalid_o = (rd_owner == RD_HOST);
        host_rdata_o  = (rd_owner == RD_HOST) ? sram_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural SRAM. Unwritten words
// read back as 32'h5000_0000 | word_index.
module tb_dmem_arbiter;

    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          core_read_i = 1'b0;
    logic          core_write_i = 1'b0;
    logic [3:0]    core_strb_i = 4'h0;
    logic [31:0]   core_addr_i = 32'h0;
    logic [31:0]   core_wdata_i = 32'h0;
    logic [31:0]   core_rdata_o;
    logic          core_stall_o;
    logic          host_req_i = 1'b0;
    logic          host_we_i = 1'b0;
    logic [3:0]    host_strb_i = 4'h0;
    logic [31:0]   host_addr_i = 32'h0;
    logic [31:0]   host_wdata_i = 32'h0;
    logic          host_gnt_o;
    logic          host_rvalid_o;
    logic [31:0]   host_rdata_o;
    logic          sram_en_o;
    logic [3:0]    sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i = 32'h0;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_read_i  (core_read_i),
        .core_write_i (core_write_i),
        .core_strb_i  (core_strb_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_rdata_o (core_rdata_o),
        .core_stall_o (core_stall_o),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_strb_i  (host_strb_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .sram_en_o    (sram_en_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM.
    logic [31:0] mem [0:(1<<AW)-1];
    logic        vld [0:(1<<AW)-1];

    function automatic logic [31:0] cur_word(input logic [AW-1:0] a);
        return vld[a] ? mem[a] : (32'h5000_0000 | 32'(a));
    endfunction

    always @(posedge clk_i) begin
        if (sram_en_o) begin
            if (sram_we_o == 4'b0000) begin
                sram_rdata_i <= cur_word(sram_addr_o);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    mem[sram_addr_o][8*b +: 8] <= sram_we_o[b] ? sram_wdata_o[8*b +: 8]
                                                               : cur_word(sram_addr_o)[8*b +: 8];
                end
                vld[sram_addr_o] <= 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) vld[i] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        core_read_i  = 1'b0;
        core_write_i = 1'b0;
        core_strb_i  = 4'h0;
        core_addr_i  = 32'h0;
        core_wdata_i = 32'h0;
        host_req_i   = 1'b0;
        host_we_i    = 1'b0;
        host_strb_i  = 4'h0;
        host_addr_i  = 32'h0;
        host_wdata_i = 32'h0;
    endtask

    task automatic check_port(input string tag, input logic en, input logic [3:0] we,
                              input logic [31:0] addr, input logic gnt, input logic stall);
        check({tag, " sram_en"},   32'(sram_en_o),    32'(en));
        check({tag, " sram_we"},   32'(sram_we_o),    32'(we));
        check({tag, " sram_addr"}, 32'(sram_addr_o),  addr);
        check({tag, " host_gnt"},  32'(host_gnt_o),   32'(gnt));
        check({tag, " core_stall"}, 32'(core_stall_o), 32'(stall));
    endtask

    typedef struct {
        string       name;
        logic        c_rd;
        logic        c_wr;
        logic [3:0]  c_strb;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        h_req;
        logic        h_we;
        logic [3:0]  h_strb;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_gnt;
        logic        e_stall;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Vectors are applied back to back from wait_cnt=0; no more than two
        // consecutive host denials occur, so force_host never fires here.
        vecs[0]  = '{"idle",          0,0,4'h0,32'h0000_0000,32'h0000_0000, 0,0,4'h0,32'h0,        32'h0,         0,4'h0,32'd0,  32'h0,         0,0};
        vecs[1]  = '{"core_rd",       1,0,4'h0,32'h0000_0010,32'hAAAA_5555, 0,0,4'h0,32'h0,        32'h0,         1,4'h0,32'd4,  32'hAAAA_5555, 0,0};
        vecs[2]  = '{"core_wr",       0,1,4'h5,32'h0000_0024,32'h1122_3344, 0,0,4'h0,32'h0,        32'h0,         1,4'h5,32'd9,  32'h1122_3344, 0,0};
        vecs[3]  = '{"core_rdwr",     1,1,4'hF,32'h0000_0040,32'hCAFE_F00D, 0,0,4'h0,32'h0,        32'h0,         1,4'hF,32'd16, 32'hCAFE_F00D, 0,0};
        vecs[4]  = '{"host_rd",       0,0,4'h0,32'h0,        32'h0,         1,0,4'hC,32'h0000_0020,32'h7777_0000, 1,4'h0,32'd8,  32'h7777_0000, 1,0};
        vecs[5]  = '{"host_wr",       0,0,4'h0,32'h0,        32'h0,         1,1,4'h3,32'h0000_0008,32'h1234_ABCD, 1,4'h3,32'd2,  32'h1234_ABCD, 1,0};
        vecs[6]  = '{"both_rd",       1,0,4'h0,32'h0000_0100,32'h0,         1,1,4'hF,32'h0000_0200,32'h9999_9999, 1,4'h0,32'd64, 32'h0,         0,0};
        vecs[7]  = '{"both_wr",       0,1,4'h2,32'h0000_0104,32'h0000_BB00, 1,0,4'h0,32'h0000_0200,32'h0,         1,4'h2,32'd65, 32'h0000_BB00, 0,0};
        vecs[8]  = '{"host_junk",     0,0,4'h0,32'h0,        32'h0,         0,1,4'hF,32'h0000_0300,32'hFFFF_FFFF, 0,4'h0,32'd0,  32'h0,         0,0};
        vecs[9]  = '{"core_wr_junk",  0,1,4'h8,32'h0000_0050,32'h8800_0000, 0,1,4'hF,32'h0000_0300,32'hFFFF_FFFF, 1,4'h8,32'd20, 32'h8800_0000, 0,0};
        vecs[10] = '{"addr_top",      1,0,4'h0,32'hFFFF_FFFC,32'h0,         0,0,4'h0,32'h0,        32'h0,         1,4'h0,32'd1023,32'h0,        0,0};

        // Reset with requests pending: port must stay quiet.
        core_write_i = 1'b1;
        core_strb_i  = 4'hF;
        host_req_i   = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check_port("reset", 1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
        check("reset core_rdata",  core_rdata_o, 32'h0);
        check("reset host_rvalid", 32'(host_rvalid_o), 32'h0);
        check("reset host_rdata",  host_rdata_o, 32'h0);
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b0;

        // Table vectors.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            core_read_i  = vecs[i].c_rd;
            core_write_i = vecs[i].c_wr;
            core_strb_i  = vecs[i].c_strb;
            core_addr_i  = vecs[i].c_addr;
            core_wdata_i = vecs[i].c_wdata;
            host_req_i   = vecs[i].h_req;
            host_we_i    = vecs[i].h_we;
            host_strb_i  = vecs[i].h_strb;
            host_addr_i  = vecs[i].h_addr;
            host_wdata_i = vecs[i].h_wdata;
            #1;
            check_port(vecs[i].name, vecs[i].e_en, vecs[i].e_we, vecs[i].e_addr,
                       vecs[i].e_gnt, vecs[i].e_stall);
            check({vecs[i].name, " sram_wdata"}, sram_wdata_o, vecs[i].e_wdata);
        end

        // Core read with 1-cycle latency, then held after the request drops.
        @(negedge clk_i);
        idle_inputs();
        core_write_i = 1'b1; core_strb_i = 4'hF; core_addr_i = 32'h10; core_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        idle_inputs();
        core_read_i = 1'b1; core_addr_i = 32'h10;
        #1;
        check_port("core_ld c0", 1'b1, 4'h0, 32'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("core_ld c1 rdata", core_rdata_o, 32'hDEAD_BEEF);
        check("core_ld c1 host_rvalid", 32'(host_rvalid_o), 32'h0);
        @(negedge clk_i);
        #1;
        check("core_ld c2 hold", core_rdata_o, 32'hDEAD_BEEF);

        // Host read then core read: each return goes to its own requester.
        @(negedge clk_i);
        host_req_i = 1'b1; host_addr_i = 32'h20;
        #1;
        check_port("hrd c0", 1'b1, 4'h0, 32'd8, 1'b1, 1'b0);
        @(negedge clk_i);
        idle_inputs();
        core_read_i = 1'b1; core_addr_i = 32'h14;
        #1;
        check("hrd c1 host_rvalid", 32'(host_rvalid_o), 32'h1);
        check("hrd c1 host_rdata", host_rdata_o, 32'h5000_0008);
        check("hrd c1 core_rdata", core_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("hrd c2 core_rdata", core_rdata_o, 32'h5000_0005);
        check("hrd c2 host_rvalid", 32'(host_rvalid_o), 32'h0);
        check("hrd c2 host_rdata", host_rdata_o, 32'h0);

        // Core read+write together is a write: no return data.
        @(negedge clk_i);
        core_read_i = 1'b1; core_write_i = 1'b1; core_strb_i = 4'hF;
        core_addr_i = 32'h30; core_wdata_i = 32'h0BAD_C0DE;
        #1;
        check_port("rdwr c0", 1'b1, 4'hF, 32'd12, 1'b0, 1'b0);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("rdwr c1 core_rdata", core_rdata_o, 32'h5000_0005);
        check("rdwr mem", mem[12], 32'h0BAD_C0DE);

        // Sustained contention: host forced through every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            core_read_i = 1'b1; core_addr_i = 32'h10;
            host_req_i  = 1'b1; host_addr_i = 32'h20;
            #1;
            check_port($sformatf("starve c%0d", i), 1'b1, 4'h0,
                       (i == 4 || i == 9) ? 32'd8 : 32'd4,
                       (i == 4 || i == 9), (i == 4 || i == 9));
        end

        // Reset during a host read return.
        @(negedge clk_i);
        idle_inputs();
        host_req_i = 1'b1; host_addr_i = 32'h20;
        #1;
        check("rst_mid c0 host_gnt", 32'(host_gnt_o), 32'h1);
        @(negedge clk_i);
        rst_i = 1'b1;
        core_read_i = 1'b1; core_addr_i = 32'h10;
        #1;
        check_port("rst_mid", 1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
        check("rst_mid host_rvalid", 32'(host_rvalid_o), 32'h0);
        check("rst_mid host_rdata", host_rdata_o, 32'h0);
        check("rst_mid core_rdata", core_rdata_o, 32'h0);
        check("rst_mid wait_cnt", 32'(dut.wait_cnt), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        #1;
        check_port("post_rst c0", 1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
        check("post_rst c0 host_rvalid", 32'(host_rvalid_o), 32'h0);
        @(negedge clk_i);
        #1;
        check("post_rst c1 host_rvalid", 32'(host_rvalid_o), 32'h0);
        check("post_rst c1 sram_en", 32'(sram_en_o), 32'h0);

        // Starvation count restarts from zero after reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            core_read_i = 1'b1; core_addr_i = 32'h10;
            host_req_i  = 1'b1; host_addr_i = 32'h20;
            #1;
            check($sformatf("post_rst starve c%0d", i), 32'(host_gnt_o), 32'(i == 4));
        end
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning SRAM word-address width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive host denials before the host is forced a grant (legal range 1..15).
REQ-003 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port core_read_i  input  1  core load request (already squash/valid-qualified by the core).
REQ-006 SHALL have port core_write_i  input  1  core store request.
REQ-007 SHALL have port core_strb_i  input  4  store byte strobes.
REQ-008 SHALL have port core_addr_i  input  32  core byte address (word-aligned).
REQ-009 SHALL have port core_wdata_i  input  32  core store data.
REQ-010 SHALL have port core_rdata_o  output  32  core load data.
REQ-011 SHALL have port core_stall_o  output  1  core denied this cycle; the pipeline must hold.
REQ-012 SHALL have port host_req_i  input  1  host request; held until granted.
REQ-013 SHALL have port host_we_i  input  1  host write (1) or read (0).
REQ-014 SHALL have port host_strb_i  input  4  host write strobes.
REQ-015 SHALL have port host_addr_i  input  32  host byte address.
REQ-016 SHALL have port host_wdata_i  input  32  host write data.
REQ-017 SHALL have port host_gnt_o  output  1  host request accepted this cycle.
REQ-018 SHALL have port host_rvalid_o  output  1  host read data valid.
REQ-019 SHALL have port host_rdata_o  output  32  host read data.
REQ-020 SHALL have port sram_en_o  output  1  SRAM access enable.
REQ-021 SHALL have port sram_we_o  output  4  SRAM byte write enables.
REQ-022 SHALL have port sram_addr_o  output  AW  SRAM word address.
REQ-023 SHALL have port sram_wdata_o  output  32  SRAM write data.
REQ-024 SHALL have port sram_rdata_i  input  32  SRAM read data, valid one cycle after a read enable.

Function
REQ-025 SHALL define core_req = core_read_i | core_write_i; if both read and write are asserted, write SHALL take precedence.
REQ-026 SHALL grant combinationally each cycle as follows:
- force_host=1 and host_req_i: grant host.
- else core_req: grant core.
- else host_req_i: grant host.
- else: idle.
REQ-027 SHALL raise core_stall_o exactly when core_req is high and the host is granted.
REQ-028 SHALL pulse host_gnt_o high in each cycle the host is granted.
REQ-029 SHALL drive the granted requester onto the SRAM port:
- sram_en_o=1.
- sram_addr_o=addr[AW+1:2].
- sram_wdata_o=wdata.
- sram_we_o=strb on a write, 4'b0000 on a read.
REQ-030 SHALL drive sram_en_o=0 and sram_we_o=0 when idle.
REQ-031 SHALL maintain wait_cnt (4 bits) as follows:
- Increment when host_req_i is high and the host is not granted.
- Clear to 0 when the host is granted or host_req_i is low.
- Saturate at MAX_WAIT.
REQ-032 SHALL set force_host = (wait_cnt == MAX_WAIT).
REQ-033 SHALL register rd_owner in {NONE, CORE, HOST}, recording which requester, if any, performed a read in the previous cycle.
REQ-034 SHALL, when rd_owner==CORE, drive core_rdata_o=sram_rdata_i and capture that value into a hold register.
REQ-035 SHALL otherwise drive core_rdata_o from the hold register.
REQ-036 SHALL set host_rvalid_o=1 and host_rdata_o=sram_rdata_i exactly when rd_owner==HOST; host_rdata_o SHALL be 0 otherwise.
REQ-037 SHALL give core reads and host reads a latency of exactly 1 cycle from grant to data.
REQ-038 SHALL complete writes in the grant cycle.
REQ-039 SHALL keep back-to-back grants to either requester legal every cycle, with no bubbles inserted.
REQ-040 SHALL grant a stalled core on the following cycle if core_req is still high, because force_host clears after a host grant.
REQ-041 SHALL ignore host_we_i, host_strb_i, host_addr_i and host_wdata_i when host_req_i is low.

Reset
REQ-042 SHALL, while rst_i is high, asynchronously clear wait_cnt=0, rd_owner=NONE and hold register=0.
REQ-043 SHALL consequently hold core_rdata_o=0, host_rvalid_o=0 and host_rdata_o=0 during reset.
REQ-044 SHALL force sram_en_o=0, sram_we_o=0, host_gnt_o=0 and core_stall_o=0 while rst_i is high, regardless of requests.
REQ-045 SHALL discard any read in flight when reset is asserted mid-operation: no rvalid is produced after reset deasserts.

Verification
REQ-046 SHALL be covered by this directed scenario: core read of addr 0x10, SRAM word 4 = 0xDEADBEEF -> cycle 0 sram_en_o=1, sram_addr_o=4; cycle 1 core_rdata_o=0xDEADBEEF, which then holds after core_read_i drops.
REQ-047 SHALL be covered by this directed scenario: host write addr 0x8, strb 4'b0011, data 0x1234ABCD, core idle -> host_gnt_o=1 same cycle, sram_we_o=4'b0011, sram_addr_o=2.
REQ-048 SHALL be covered by this directed scenario: core_read_i and host_req_i both held high continuously with MAX_WAIT=4 -> core granted cycles 0-3; host granted in cycle 4 with core_stall_o=1; core granted in cycle 5; host granted again in cycle 9.
REQ-049 SHALL be covered by this directed scenario: host read of addr 0x20 followed by a core read in the next cycle -> host_rvalid_o=1 with word 8 in cycle 1, and core_rdata_o updated in cycle 2 only.
REQ-050 SHALL be covered by this directed scenario: core_read_i and core_write_i both high, strb 4'hF -> sram_we_o=4'hF, and core_rdata_o unchanged in the next cycle.
REQ-051 SHALL be covered by this directed scenario: host read granted, then rst_i pulsed high in the following cycle -> host_rvalid_o=0 and wait_cnt=0; after release, the arbiter is idle until new requests arrive.
